// File: rtl/bp_be_itag_tracker.sv
// bp_be_itag_tracker: in-order itag/PC tracker for backend in-flight instructions.
// Define BP_BE_ITAG_FLUSH_CNT_EN to add flush_cnt_o, a saturating count of flushed entries.
module bp_be_itag_tracker #(
  parameter int itag_width_p = 8,
  parameter int depth_p = 5,
  parameter int pc_width_p = 64,
  localparam int cnt_w = $clog2(depth_p + 1),
  localparam int ptr_w = (depth_p > 1) ? $clog2(depth_p) : 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    alloc_v_i,
  input  logic [pc_width_p-1:0]   alloc_pc_i,
  output logic                    alloc_ready_o,
  output logic [itag_width_p-1:0] alloc_itag_o,
  input  logic                    commit_v_i,
  input  logic [itag_width_p-1:0] commit_itag_i,
  input  logic                    flush_i,
  output logic                    oldest_v_o,
  output logic [itag_width_p-1:0] oldest_itag_o,
  output logic [pc_width_p-1:0]   oldest_pc_o,
  output logic [cnt_w-1:0]        count_o,
  output logic                    err_o
`ifdef BP_BE_ITAG_FLUSH_CNT_EN
  ,
  output logic [15:0]             flush_cnt_o
`endif
);
  if (itag_width_p < 31 && (1 << itag_width_p) <= depth_p) begin : g_bad_width
    $error("bp_be_itag_tracker: 2**itag_width_p must exceed depth_p");
  end
  logic [itag_width_p-1:0] tag_r;
  logic [ptr_w-1:0] head_r, tail_r;
  logic [cnt_w-1:0] count_r;
  logic err_r;
  logic [itag_width_p-1:0] tag_q [depth_p];
  logic [pc_width_p-1:0] pc_q [depth_p];
  logic alloc_acc, commit_acc, commit_bad;
  function automatic logic [ptr_w-1:0] nxt(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth_p - 1)) ? '0 : p + 1'b1;
  endfunction
  assign alloc_ready_o = count_r != cnt_w'(depth_p);
  assign alloc_itag_o = tag_r;
  assign oldest_v_o = count_r != '0;
  assign oldest_itag_o = oldest_v_o ? tag_q[head_r] : '0;
  assign oldest_pc_o = oldest_v_o ? pc_q[head_r] : '0;
  assign count_o = count_r;
  assign err_o = err_r;
  assign alloc_acc = alloc_v_i & alloc_ready_o & ~flush_i;
  assign commit_acc = commit_v_i & oldest_v_o & ~flush_i & (commit_itag_i == oldest_itag_o);
  assign commit_bad = commit_v_i & ~flush_i & ~commit_acc;
  // The tag counter keeps advancing across flushes so discarded tags are not reissued early.
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      tag_r <= '0;
      head_r <= '0;
      tail_r <= '0;
      count_r <= '0;
      err_r <= 1'b0;
    end else begin
      tag_r <= tag_r + itag_width_p'(alloc_acc);
      head_r <= flush_i ? '0 : commit_acc ? nxt(head_r) : head_r;
      tail_r <= flush_i ? '0 : alloc_acc ? nxt(tail_r) : tail_r;
      count_r <= flush_i ? '0 : count_r + cnt_w'(alloc_acc) - cnt_w'(commit_acc);
      err_r <= err_r | commit_bad;
    end
  always_ff @(posedge clk_i)
    if (alloc_acc) begin
      tag_q[tail_r] <= tag_r;
      pc_q[tail_r] <= alloc_pc_i;
    end
`ifdef BP_BE_ITAG_FLUSH_CNT_EN
  logic [16:0] flush_sum;
  assign flush_sum = 17'(flush_cnt_o) + 17'(count_r);
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) flush_cnt_o <= '0;
    else if (flush_i) flush_cnt_o <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
`endif
endmodule

// File: tb/tb_bp_be_itag_tracker.sv
// tb_bp_be_itag_tracker: directed scoreboard bench for bp_be_itag_tracker.
module tb_bp_be_itag_tracker;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  logic alloc_v_i = 1'b0;
  logic [63:0] alloc_pc_i = '0;
  logic alloc_ready_o;
  logic [7:0] alloc_itag_o;
  logic commit_v_i = 1'b0;
  logic [7:0] commit_itag_i = '0;
  logic flush_i = 1'b0;
  logic oldest_v_o;
  logic [7:0] oldest_itag_o;
  logic [63:0] oldest_pc_o;
  logic [2:0] count_o;
  logic err_o;
`ifdef BP_BE_ITAG_FLUSH_CNT_EN
  logic [15:0] flush_cnt_o;
`endif
  int checks = 0;
  int failures = 0;
  typedef struct {logic [7:0] tag; logic [63:0] pc;} ent_t;
  ent_t sb[$];
  logic [7:0] exp_tag = '0;

  bp_be_itag_tracker dut (
    .clk_i(clk_i), .reset_i(reset_i), .alloc_v_i(alloc_v_i), .alloc_pc_i(alloc_pc_i),
    .alloc_ready_o(alloc_ready_o), .alloc_itag_o(alloc_itag_o), .commit_v_i(commit_v_i),
    .commit_itag_i(commit_itag_i), .flush_i(flush_i), .oldest_v_o(oldest_v_o),
    .oldest_itag_o(oldest_itag_o), .oldest_pc_o(oldest_pc_o), .count_o(count_o),
`ifdef BP_BE_ITAG_FLUSH_CNT_EN
    .flush_cnt_o(flush_cnt_o),
`endif
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_oldest;
    chk("count", 64'(count_o), 64'(sb.size()));
    if (sb.size() == 0) begin
      chk("oldest_v_empty", 64'(oldest_v_o), 64'd0);
      chk("oldest_itag_empty", 64'(oldest_itag_o), 64'd0);
      chk("oldest_pc_empty", oldest_pc_o, 64'd0);
    end else begin
      chk("oldest_v", 64'(oldest_v_o), 64'd1);
      chk("oldest_itag", 64'(oldest_itag_o), 64'(sb[0].tag));
      chk("oldest_pc", oldest_pc_o, sb[0].pc);
    end
  endtask

  task automatic alloc(input logic [63:0] pc);
    chk("alloc_ready", 64'(alloc_ready_o), 64'd1);
    chk("alloc_itag", 64'(alloc_itag_o), 64'(exp_tag));
    alloc_v_i = 1'b1;
    alloc_pc_i = pc;
    tick;
    alloc_v_i = 1'b0;
    sb.push_back('{exp_tag, pc});
    exp_tag++;
  endtask

  task automatic commit;
    check_oldest;
    commit_v_i = 1'b1;
    commit_itag_i = sb[0].tag;
    tick;
    commit_v_i = 1'b0;
    void'(sb.pop_front());
    check_oldest;
  endtask

  task automatic pair(input logic [63:0] pc);
    check_oldest;
    chk("pair_itag", 64'(alloc_itag_o), 64'(exp_tag));
    alloc_v_i = 1'b1;
    alloc_pc_i = pc;
    commit_v_i = 1'b1;
    commit_itag_i = sb[0].tag;
    tick;
    alloc_v_i = 1'b0;
    commit_v_i = 1'b0;
    void'(sb.pop_front());
    sb.push_back('{exp_tag, pc});
    exp_tag++;
  endtask

  task automatic do_reset;
    reset_i = 1'b1;
    tick;
    sb.delete();
    exp_tag = '0;
    chk("rst_ready", 64'(alloc_ready_o), 64'd1);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_itag", 64'(alloc_itag_o), 64'd0);
    check_oldest;
    reset_i = 1'b0;
  endtask

  initial begin
    tick;
    do_reset;
    // Three allocations after reset receive tags 0, 1, 2.
    alloc(64'h80000124);
    alloc(64'h80000128);
    alloc(64'h8000012C);
    check_oldest;
    chk("first_pc", oldest_pc_o, 64'h80000124);
    chk("first_tag", 64'(oldest_itag_o), 64'd0);
    // Fill, then alloc+commit while full: only the commit takes effect.
    alloc(64'h80000130);
    alloc(64'h80000134);
    check_oldest;
    chk("full_ready", 64'(alloc_ready_o), 64'd0);
    alloc_v_i = 1'b1;
    alloc_pc_i = 64'hDEAD0000;
    commit_v_i = 1'b1;
    commit_itag_i = sb[0].tag;
    tick;
    alloc_v_i = 1'b0;
    commit_v_i = 1'b0;
    void'(sb.pop_front());
    check_oldest;
    chk("full_commit_ready", 64'(alloc_ready_o), 64'd1);
    chk("full_commit_itag", 64'(alloc_itag_o), 64'(exp_tag));
    // Out-of-order commit sets sticky err and does not pop.
    do_reset;
    alloc(64'h1000);
    alloc(64'h1004);
    commit_v_i = 1'b1;
    commit_itag_i = 8'd1;
    tick;
    commit_v_i = 1'b0;
    check_oldest;
    chk("err_set", 64'(err_o), 64'd1);
    tick;
    tick;
    chk("err_sticky", 64'(err_o), 64'd1);
    commit;
    commit;
    for (int i = 0; i < 3; i++) begin
      alloc(64'h2000 + 64'(i * 4));
      commit;
    end
    // Flush with tags 5,6,7 in flight beats a same-cycle alloc and commit.
    alloc(64'h3000);
    alloc(64'h3004);
    alloc(64'h3008);
    check_oldest;
    alloc_v_i = 1'b1;
    alloc_pc_i = 64'hBAD;
    commit_v_i = 1'b1;
    commit_itag_i = sb[0].tag;
    flush_i = 1'b1;
    tick;
    alloc_v_i = 1'b0;
    commit_v_i = 1'b0;
    flush_i = 1'b0;
    sb.delete();
    check_oldest;
    chk("flush_next_itag", 64'(alloc_itag_o), 64'd8);
`ifdef BP_BE_ITAG_FLUSH_CNT_EN
    chk("flush_cnt", 64'(flush_cnt_o), 64'd3);
`endif
    alloc(64'h4000);
    commit;
    // Long run of overlapped alloc/commit pairs wraps the tag counter and pointers.
    do_reset;
    alloc(64'h5000);
    alloc(64'h5004);
    for (int i = 0; i < 300; i++) pair(64'h6000 + 64'(i * 4));
    check_oldest;
    chk("wrap_err", 64'(err_o), 64'd0);
    commit;
    commit;
    // Asynchronous reset mid-cycle with 4 in flight and err set.
    alloc(64'h7000);
    alloc(64'h7004);
    alloc(64'h7008);
    alloc(64'h700C);
    commit_v_i = 1'b1;
    commit_itag_i = sb[0].tag + 8'd1;
    tick;
    commit_v_i = 1'b0;
    chk("pre_rst_err", 64'(err_o), 64'd1);
    check_oldest;
    @(posedge clk_i);
    #3;
    reset_i = 1'b1;
    #1;
    sb.delete();
    exp_tag = '0;
    check_oldest;
    chk("async_ready", 64'(alloc_ready_o), 64'd1);
    chk("async_err", 64'(err_o), 64'd0);
    chk("async_itag", 64'(alloc_itag_o), 64'd0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    alloc(64'h8000);
    commit;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bp_be_itag_tracker.md
BP_BE_ITAG_TRACKER -- requirements
Module: bp_be_itag_tracker

Interface
REQ-001 SHALL have parameter itag_width_p, default 8, instruction tag width.
REQ-002 SHALL have parameter depth_p, default 5, maximum number of in-flight entries (one per backend pipe stage).
REQ-003 SHALL have parameter pc_width_p, default 64, width of the PC payload per entry.
REQ-004 SHALL have the port clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have the port reset_i  in  1  asynchronous, active-high reset.
REQ-006 SHALL have the port alloc_v_i  in  1  allocation request.
REQ-007 SHALL have the port alloc_pc_i  in  pc_width_p  PC stored with the new entry.
REQ-008 SHALL have the port alloc_ready_o  out  1  allocation can be accepted.
REQ-009 SHALL have the port alloc_itag_o  out  itag_width_p  tag assigned to the next accepted allocation.
REQ-010 SHALL have the port commit_v_i  in  1  in-order retire request.
REQ-011 SHALL have the port commit_itag_i  in  itag_width_p  tag being retired.
REQ-012 SHALL have the port flush_i  in  1  discard all in-flight entries.
REQ-013 SHALL have the port oldest_v_o  out  1  at least one entry in flight.
REQ-014 SHALL have the port oldest_itag_o  out  itag_width_p  tag of the oldest entry.
REQ-015 SHALL have the port oldest_pc_o  out  pc_width_p  PC of the oldest entry.
REQ-016 SHALL have the port count_o  out  $clog2(depth_p+1)  number of entries in flight.
REQ-017 SHALL have the port err_o  out  1  sticky commit-order violation.

Function
REQ-018 Allocation SHALL be accepted when alloc_v_i & alloc_ready_o & ~flush_i; the entry {alloc_itag_o, alloc_pc_i} is written at the tail, and the tag counter then increments modulo 2^itag_width_p (wrapping from all-ones to 0).
REQ-019 alloc_ready_o SHALL equal (count_o != depth_p), driven from registered count only; a same-cycle commit SHALL NOT make a full tracker ready.
REQ-020 A commit SHALL be accepted when commit_v_i & oldest_v_o & ~flush_i & (commit_itag_i == oldest_itag_o); the head entry is popped.
REQ-021 commit_v_i with an empty tracker or a mismatching tag SHALL NOT pop, and SHALL set err_o, which stays set until reset.
REQ-022 A simultaneous accepted allocation and commit SHALL leave count_o unchanged, with the head and tail pointers both advancing and wrapping at depth_p.
REQ-023 flush_i SHALL take priority: count_o becomes 0 next cycle, the same-cycle allocation and commit are ignored, and the tag counter does not rewind (discarded tags are never reused before wrap).
REQ-024 oldest_*_o and count_o SHALL be combinational from registered state (zero-latency view); a new entry becomes visible one cycle after acceptance.
REQ-025 When oldest_v_o is 0, oldest_itag_o and oldest_pc_o SHALL be 0.
REQ-026 The design SHALL check at elaboration that 2^itag_width_p > depth_p.

Reset
REQ-027 On reset_i assertion, asynchronously and at any point mid-operation: count_o=0, the tag counter=0, the head and tail pointers=0, err_o=0, oldest_v_o=0, and alloc_ready_o=1.
REQ-028 Entry storage SHALL NOT require reset.
REQ-029 The first allocation after reset SHALL receive tag 0.

Configuration
REQ-030 With BP_BE_ITAG_FLUSH_CNT_EN defined, the design SHALL add the port flush_cnt_o  out  16, a saturating (at 16'hFFFF) total of entries discarded by flush_i, which resets to 0.
REQ-031 Without BP_BE_ITAG_FLUSH_CNT_EN, the flush_cnt_o port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 The bench SHALL cover: reset, then allocate PCs 0x80000124, 0x80000128, 0x8000012C -> tags 0, 1, 2; count_o=3; oldest_itag_o=0; oldest_pc_o=0x80000124.
REQ-033 The bench SHALL cover: fill to 5 entries, then alloc+commit in the same cycle -> commit pops, the allocation is not accepted, alloc_ready_o=1 the next cycle, and count_o=4.
REQ-034 The bench SHALL cover: with 2 entries in flight, commit with tag 1 while the oldest is tag 0 -> no pop, count_o=2, err_o=1 and remaining sticky.
REQ-035 The bench SHALL cover: 3 in flight at tags 5, 6, 7, then flush_i with alloc_v_i -> count_o=0, the next allocation gets tag 8, and flush_cnt_o=3 when the macro is enabled.
REQ-036 The bench SHALL cover: 300 alloc/commit pairs -> tags wrap from 255 to 0 with no err_o and no pointer corruption.
REQ-037 The bench SHALL cover: reset_i asserted asynchronously between edges with 4 in flight -> outputs immediately return to the REQ-027 values, and the next allocation gets tag 0.
